// File: rtl/reverse_double_dabble.sv
// reverse_double_dabble: sequential BCD-to-binary converter (reverse double dabble).
// Ports:
//   i_Clock  - clock, all logic on the rising edge
//   i_Reset  - synchronous active-high reset
//   i_BCD    - packed BCD operand, digit 0 in bits [3:0], sampled on the start edge
//   i_Start  - start request, honoured only when idle
//   o_Binary - registered binary result, held until the next completion
//   o_DV     - one-cycle pulse marking a new o_Binary/o_Error
//   o_Busy   - high while a conversion is in flight
//   o_Error  - invalid-digit flag, updated with o_DV
// Optional feature: define BCD_CHECK_EN to flag digits > 9 and finish early with
// o_Binary = 0 and o_Error = 1; without it o_Error stays 0.
module reverse_double_dabble #(
    parameter int INPUT_DIGITS = 3,
    parameter int OUTPUT_WIDTH = 10
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [INPUT_DIGITS*4-1:0] i_BCD,
    input  logic                      i_Start,
    output logic [OUTPUT_WIDTH-1:0]   o_Binary,
    output logic                      o_DV,
    output logic                      o_Busy,
    output logic                      o_Error
);
    localparam int BW = INPUT_DIGITS * 4;
    localparam int LW = $clog2(OUTPUT_WIDTH + 1);
    localparam int DW = $clog2(INPUT_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK_SHIFT_INDEX,
        SUB,
        CHECK_DIGIT_INDEX,
        DONE
    } state_t;

    state_t                  state;
    logic [BW-1:0]           r_bcd;
    logic [OUTPUT_WIDTH-1:0] r_bin;
    logic [LW-1:0]           loop_cnt;
    logic [DW-1:0]           dig_idx;
    logic                    err;
    logic                    bad;
    logic [3:0]              dig;

    assign dig = r_bcd[dig_idx*4 +: 4];

`ifdef BCD_CHECK_EN
    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < INPUT_DIGITS; k++)
            bad = bad | (i_BCD[k*4 +: 4] > 4'd9);
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= IDLE;
            r_bcd    <= '0;
            r_bin    <= '0;
            loop_cnt <= '0;
            dig_idx  <= '0;
            err      <= 1'b0;
            o_Binary <= '0;
            o_DV     <= 1'b0;
            o_Busy   <= 1'b0;
            o_Error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_DV <= 1'b0;
                    if (i_Start) begin
                        r_bcd    <= i_BCD;
                        r_bin    <= '0;
                        loop_cnt <= '0;
                        dig_idx  <= '0;
                        err      <= bad;
                        o_Busy   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // An invalid operand skips the algorithm; r_bin is still zero here.
                    if (err) begin
                        state <= DONE;
                    end else begin
                        {r_bcd, r_bin} <= {r_bcd, r_bin} >> 1;
                        state          <= CHECK_SHIFT_INDEX;
                    end
                end
                CHECK_SHIFT_INDEX: begin
                    if (loop_cnt == LW'(OUTPUT_WIDTH - 1)) begin
                        loop_cnt <= '0;
                        state    <= DONE;
                    end else begin
                        loop_cnt <= loop_cnt + 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    // Correction stays inside the 4-bit digit; no borrow to neighbours.
                    if (dig >= 4'd8)
                        r_bcd[dig_idx*4 +: 4] <= dig - 4'd3;
                    state <= CHECK_DIGIT_INDEX;
                end
                CHECK_DIGIT_INDEX: begin
                    if (dig_idx == DW'(INPUT_DIGITS - 1)) begin
                        dig_idx <= '0;
                        state   <= SHIFT;
                    end else begin
                        dig_idx <= dig_idx + 1'b1;
                        state   <= SUB;
                    end
                end
                DONE: begin
                    o_Binary <= r_bin;
                    o_Error  <= err;
                    o_DV     <= 1'b1;
                    o_Busy   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reverse_double_dabble.sv
// tb_reverse_double_dabble: randomized and directed self-checking bench with a behavioural model.
module tb_reverse_double_dabble;
    localparam int D = 3;
    localparam int W = 10;
    localparam int L = (W - 1) * (2 * D + 2) + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [D*4-1:0] bcd;
    logic           start;
    logic [W-1:0]   binary;
    logic           dv;
    logic           busy;
    logic           error;

    int n_cmp = 0;
    int n_bad = 0;

    reverse_double_dabble #(.INPUT_DIGITS(D), .OUTPUT_WIDTH(W)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .i_BCD   (bcd),
        .i_Start (start),
        .o_Binary(binary),
        .o_DV    (dv),
        .o_Busy  (busy),
        .o_Error (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a conversion accepted at edge n completes at edge n+L
    // with the decimal value of the operand modulo 2^W.
    int           ne = 0;
    int           done_at = -1;
    int           start_at = -10;
    logic         armed = 1'b0;
    logic         m_dv = 1'b0, m_err = 1'b0, m_known = 1'b1;
    logic [W-1:0] m_bin = '0;
    logic [W-1:0] p_bin;
    logic         p_err, p_known;

    initial forever begin
        @(posedge clk);
        ne++;
        if (rst) begin
            armed   = 1'b1;
            done_at = -1;
            m_dv    = 1'b0;
            m_err   = 1'b0;
            m_bin   = '0;
            m_known = 1'b1;
        end else if (armed) begin
            if (done_at == ne) begin
                m_dv    = 1'b1;
                m_bin   = p_bin;
                m_err   = p_err;
                m_known = p_known;
                done_at = -1;
            end else begin
                m_dv = 1'b0;
                if (done_at < 0 && start) begin
                    int   val;
                    logic ok;
                    val = 0;
                    ok  = 1'b1;
                    for (int k = D - 1; k >= 0; k--) begin
                        val = val * 10 + int'(bcd[k*4 +: 4]);
                        ok  = ok & (bcd[k*4 +: 4] <= 4'd9);
                    end
                    start_at = ne;
`ifdef BCD_CHECK_EN
                    p_err   = !ok;
                    p_bin   = ok ? val[W-1:0] : '0;
                    p_known = 1'b1;
                    done_at = ne + (ok ? L : 2);
`else
                    p_err   = 1'b0;
                    p_bin   = val[W-1:0];
                    p_known = ok;
                    done_at = ne + L;
`endif
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("dv", dv, m_dv);
            chk("error", error, m_err);
            if (m_known) chk("binary", binary, m_bin);
            if (ne != start_at) chk("busy", busy, done_at >= 0);
        end
    end

    task automatic conv(input logic [D*4-1:0] v, input int exp_v, input int exp_lat,
                        input logic chk_v, input logic exp_e);
        int lat;
        lat   = -1;
        bcd   = v;
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            bcd   = D*4'($urandom);
            if (dv) begin
                lat = c - 1;
                break;
            end
        end
        chk("latency", lat, exp_lat);
        if (chk_v) chk("value", binary, exp_v);
        chk("err_flag", error, exp_e);
        chk("busy_in_dv", busy, 0);
        @(negedge clk);
        chk("dv_one_cycle", dv, 0);
    endtask

    initial begin
        int ndv, first, dvc[$];
        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        repeat (3) @(negedge clk);
        chk("rst_binary", binary, 0);
        chk("rst_dv", dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);

        conv(12'h999, 999, 75, 1'b1, 1'b0);
        conv(12'h000, 0, L, 1'b1, 1'b0);
        conv(12'h255, 255, L, 1'b1, 1'b0);
        conv(12'h001, 1, L, 1'b1, 1'b0);
        conv(12'h512, 512, L, 1'b1, 1'b0);

        // Start while busy is ignored.
        bcd   = 12'h123;
        start = 1'b1;
        ndv   = 0;
        first = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == 10);
            bcd   = (c == 10) ? 12'h456 : 12'h123;
            if (dv) begin
                ndv++;
                if (first < 0) first = int'(binary);
            end
        end
        chk("ignored_start_dv_count", ndv, 1);
        chk("ignored_start_value", first, 123);

        // Reset mid-conversion aborts with no completion.
        bcd   = 12'h777;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_binary", binary, 0);
        chk("abort_dv", dv, 0);
        chk("abort_busy", busy, 0);
        chk("abort_error", error, 0);
        rst = 1'b0;
        ndv = 0;
        repeat (100) begin
            @(negedge clk);
            if (dv) ndv++;
        end
        chk("abort_no_dv", ndv, 0);
        conv(12'h042, 42, L, 1'b1, 1'b0);

        // Start held high: back-to-back conversions.
        bcd   = 12'h500;
        start = 1'b1;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk);
            if (dv) begin
                dvc.push_back(c);
                chk("b2b_value", binary, 500);
            end
        end
        start = 1'b0;
        chk("b2b_count", dvc.size(), 3);
        if (dvc.size() >= 3) begin
            chk("b2b_gap1", dvc[1] - dvc[0], 76);
            chk("b2b_gap2", dvc[2] - dvc[1], 76);
        end
        repeat (100) @(negedge clk);

        // Start coinciding with reset is ignored.
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        ndv   = 0;
        repeat (80) begin
            @(negedge clk);
            if (dv || busy) ndv++;
        end
        chk("start_with_reset_ignored", ndv, 0);

`ifdef BCD_CHECK_EN
        conv(12'h1A5, 0, 2, 1'b1, 1'b1);
`else
        conv(12'h1A5, 0, L, 1'b0, 1'b0);
`endif
        conv(12'h999, 999, L, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < D; k++) bcd[k*4 +: 4] = 4'($urandom_range(0, 9));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(60, 100)) begin
                bcd = D*4'($urandom);
                for (int k = 0; k < D; k++)
                    if (bcd[k*4 +: 4] > 4'd9) bcd[k*4 +: 4] = bcd[k*4 +: 4] - 4'd6;
                start = ($urandom_range(0, 7) == 0);
                rst   = ($urandom_range(0, 299) == 0);
                @(negedge clk);
            end
            start = 1'b0;
            rst   = 1'b0;
        end
        repeat (100) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
